// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multicycle core: PC stall encodings,
// fetch state encoding and the canonical NOP word.
package core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam logic [1:0] STALL_ADV  = 2'd0;
  localparam logic [1:0] STALL_BACK = 2'd1;
  localparam logic [1:0] STALL_HOLD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DRAIN
  } fetch_state_t;

  localparam word_t NOP_WORD = 32'h00000013;  // addi x0, x0, 0

  function automatic logic is_word_aligned(input word_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory read port: single outstanding req/ack transaction.
interface ifetch_unit_if;

  logic          mem_req;
  core_pkg::word_t mem_addr;
  logic          mem_ack;
  core_pkg::word_t mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one memory read per instruction, holds the word for
// decode and stalls the PC until decode accepts it or a redirect occurs.
module ifetch_unit
  import core_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  word_t                pc_addr,
  input  logic                 flush,
  input  logic                 id_ready,
  output logic [1:0]           stall_op,
  ifetch_unit_if.master        mem,
  output word_t                instr,
  output logic                 instr_valid,
  output logic                 fault
);

  fetch_state_t state_q;

  word_t addr_q;
  word_t addr_d;
  word_t instr_q;
  word_t instr_d;
  logic  valid_q;
  logic  valid_d;
  logic  fault_q;
  logic  fault_d;

  logic aligned_c;
  logic accept_c;

  assign aligned_c = is_word_aligned(pc_addr);
  assign accept_c  = valid_q && id_ready;

  // A request is only on the bus while a read is actually outstanding.
  assign mem.mem_req  = ((state_q == S_REQ) && aligned_c) ||
                        (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign mem.mem_addr = addr_q;

  assign stall_op = (reset && (flush || accept_c)) ? STALL_ADV : STALL_HOLD;

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

  // State register with next-state decode. A flush that races an ack from
  // S_WAIT has nothing left to drain, and a flush during S_DRAIN keeps
  // waiting for the abandoned read so only one request is ever outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (flush) begin
            state_q <= (aligned_c && !mem.mem_ack) ? S_DRAIN : S_REQ;
          end else if (!aligned_c || mem.mem_ack) begin
            state_q <= S_VALID;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            state_q <= flush ? S_REQ : S_VALID;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_VALID: begin
          if (flush || id_ready) begin
            state_q <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem.mem_ack) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output register next values; flush overrides any capture this cycle.
  always_comb begin
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;

    if (state_q == S_REQ) begin
      addr_d = pc_addr;
    end

    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!aligned_c) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b1;
            fault_d = 1'b1;
          end else if (mem.mem_ack) begin
            instr_d = mem.mem_rdata;
            valid_d = 1'b1;
            fault_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            instr_d = mem.mem_rdata;
            valid_d = 1'b1;
            fault_d = 1'b0;
          end
        end
        S_VALID: begin
          if (id_ready) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the fetch unit.
module tb_ifetch_unit;
  import core_pkg::*;

  logic       clk;
  logic       reset;
  word_t      pc;
  logic       flush;
  logic       id_ready;
  logic [1:0] stall_op;
  word_t      instr;
  logic       instr_valid;
  logic       fault;

  ifetch_unit_if mem_bus ();

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc),
    .flush       (flush),
    .id_ready    (id_ready),
    .stall_op    (stall_op),
    .mem         (mem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  int    age = 0;
  int    lat_cur = 0;
  int    force_lat = 0;
  logic  ovr_en = 1'b0;
  word_t ovr_data = '0;

  // Transaction-level model of the fetch unit
  logic  m_idle, m_sample, m_pend, m_drop, m_valid, m_fault;
  word_t m_instr, m_addr;

  logic       c_req;
  logic [1:0] c_stall;

  localparam word_t NOP = 32'h00000013;

  function automatic word_t mem_word(input word_t a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_sample = 1'b0; m_pend = 1'b0; m_drop = 1'b0;
    m_valid = 1'b0; m_fault = 1'b0; m_instr = NOP; m_addr = '0;
    age = 0; pc = '0;
  endtask

  task automatic kill();
    m_valid = 1'b0; m_fault = 1'b0; m_instr = NOP;
  endtask

  // One clock cycle: entered just after a falling edge, leaves at the next one.
  task automatic step(input logic fl, input logic rdy, input word_t tgt);
    logic       ack;
    logic       pred_req;
    logic [1:0] pred_stall;
    logic       aligned;
    word_t      rd, raddr, pc_pre;
    flush    = fl;
    id_ready = rdy;
    ack      = 1'b0;
    raddr    = (age == 0) ? pc : mem_bus.mem_addr;
    if (mem_bus.mem_req) begin
      if (age == 0) lat_cur = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      ack = (age == lat_cur);
    end
    rd = ack ? (ovr_en ? ovr_data : mem_word(raddr)) : word_t'($urandom);
    mem_bus.mem_ack   = ack;
    mem_bus.mem_rdata = rd;
    pred_req   = (m_sample && (pc[1:0] == 2'b00)) || m_pend;
    pred_stall = (fl || (m_valid && rdy)) ? 2'd0 : 2'd2;
    #1;
    c_req   = mem_bus.mem_req;
    c_stall = stall_op;
    chk("mem_req", 32'(c_req), 32'(pred_req));
    chk("stall_op", 32'(c_stall), 32'(pred_stall));
    @(posedge clk);
    #1;
    pc_pre  = pc;
    aligned = (pc_pre[1:0] == 2'b00);
    if (ack) age = 0;
    else if (c_req) age++;
    if (fl) pc = tgt;
    else if (pred_stall == 2'd0) pc = pc + 32'd4;
    if (m_idle) begin
      m_idle = 1'b0; m_sample = 1'b1;
    end else if (m_sample) begin
      m_addr = pc_pre;
      if (fl) begin
        kill();
        m_pend   = aligned && !ack;
        m_sample = !m_pend;
        m_drop   = 1'b1;
      end else if (!aligned) begin
        m_instr = NOP; m_fault = 1'b1; m_valid = 1'b1; m_sample = 1'b0;
      end else if (ack) begin
        m_instr = rd; m_fault = 1'b0; m_valid = 1'b1; m_sample = 1'b0;
      end else begin
        m_pend = 1'b1; m_drop = 1'b0; m_sample = 1'b0;
      end
    end else if (m_pend) begin
      if (fl) begin kill(); m_drop = 1'b1; end
      if (ack) begin
        m_pend = 1'b0;
        if (m_drop) m_sample = 1'b1;
        else begin m_instr = rd; m_fault = 1'b0; m_valid = 1'b1; end
      end
    end else if (m_valid) begin
      if (fl) begin kill(); m_sample = 1'b1; end
      else if (rdy) begin m_valid = 1'b0; m_fault = 1'b0; m_sample = 1'b1; end
    end
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", instr, m_instr);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("mem_addr", mem_bus.mem_addr, m_addr);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    n_req, bad_stall, bad_req, iters;
    word_t held;
    logic  fl, rdy;
    word_t tgt;

    reset = 1'b0; flush = 1'b0; id_ready = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_stall_op", 32'(stall_op), 32'd2);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    // Zero-wait fetch of addr 0
    force_lat = 0;
    step(1'b0, 1'b1, '0);
    chk("t1_c0_req", 32'(c_req), 32'd0);
    step(1'b0, 1'b1, '0);
    chk("t1_c1_req", 32'(c_req), 32'd1);
    chk("t1_c1_stall", 32'(c_stall), 32'd2);
    chk("t1_c2_valid", 32'(instr_valid), 32'd1);
    chk("t1_c2_instr", instr, 32'h00500093);
    step(1'b0, 1'b1, '0);
    chk("t1_c2_stall", 32'(c_stall), 32'd0);

    // Three-cycle memory latency
    force_lat = 3; n_req = 0; bad_stall = 0; iters = 0;
    while (!instr_valid && iters < 10) begin
      step(1'b0, 1'b1, '0);
      n_req += int'(c_req);
      if (c_stall != 2'd2) bad_stall++;
      iters++;
    end
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_req_cycles", 32'(n_req), 32'd4);
    chk("t2_stall_hold", 32'(bad_stall), 32'd0);
    chk("t2_addr", mem_bus.mem_addr, 32'h4);

    // Decode back-pressure
    held = instr; bad_stall = 0; bad_req = 0;
    repeat (5) begin
      step(1'b0, 1'b0, '0);
      if (c_stall != 2'd2) bad_stall++;
      if (c_req) bad_req++;
    end
    chk("t3_instr_held", instr, held);
    chk("t3_stall_hold", 32'(bad_stall), 32'd0);
    chk("t3_no_req", 32'(bad_req), 32'd0);
    step(1'b0, 1'b1, '0);

    // Flush in S_WAIT, late ack discarded, refetch at target
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 32'h40);
    chk("t4_flush_valid", 32'(instr_valid), 32'd0);
    chk("t4_flush_instr", instr, 32'h00000013);
    ovr_en = 1'b1; ovr_data = 32'hDEADBEEF;
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("t4_discard_valid", 32'(instr_valid), 32'd0);
    chk("t4_discard_instr", instr, 32'h00000013);
    ovr_en = 1'b0;
    step(1'b0, 1'b0, '0);
    chk("t4_new_req", 32'(c_req), 32'd1);
    chk("t4_new_addr", mem_bus.mem_addr, 32'h40);
    iters = 0;
    while (!instr_valid && iters < 10) begin
      step(1'b0, 1'b0, '0);
      iters++;
    end
    chk("t4_refetch_valid", 32'(instr_valid), 32'd1);

    // Misaligned target
    step(1'b1, 1'b0, 32'h42);
    step(1'b0, 1'b0, '0);
    chk("t5_no_req", 32'(c_req), 32'd0);
    chk("t5_instr", instr, 32'h00000013);
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_valid", 32'(instr_valid), 32'd1);
    step(1'b0, 1'b1, '0);
    chk("t5_fault_once", 32'(fault), 32'd0);
    step(1'b1, 1'b0, 32'h80);

    // Reset while a request is outstanding
    step(1'b0, 1'b1, '0);
    chk("t6_pre_req", 32'(mem_bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("t6_stall_op", 32'(stall_op), 32'd2);
    chk("t6_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("t6_instr", instr, 32'h00000013);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    mem_bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;

    // Random traffic
    force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = word_t'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) tgt = tgt | word_t'($urandom_range(1, 3));
      step(fl, rdy, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the multicycle RV32I core. It sits between the PC register and instruction memory, and consumes the PC address output. It issues one memory read per instruction over a req/ack handshake and holds the fetched word for decode. It drives the PC's `stall_op` so the PC advances only when decode has accepted an instruction or a redirect occurs.

## Interface
- `NOP_INSTR`, default 32'h00000013: word presented on `instr` after reset, flush, or a misaligned fetch.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `pc_addr`  in  32  current PC address (PC `addr` output).
- `flush`  in  1  redirect: PC loads branch/jump target this cycle.
- `id_ready`  in  1  decode accepts `instr` this cycle.
- `stall_op`  out  2  to PC: 2'd0 advance, 2'd2 hold; 2'd1 (rollback) is never driven by this block.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  32  word-aligned read address.
- `mem_ack`  in  1  memory response valid; `mem_rdata` is sampled in the same cycle.
- `mem_rdata`  in  32  read data.
- `instr`  out  32  fetched instruction, registered.
- `instr_valid`  out  1  `instr` is valid for decode.
- `fault`  out  1  qualifies `instr_valid`: misaligned fetch address.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_VALID, S_DRAIN.
- S_IDLE: entered on reset. Go to S_REQ on the next clock.
- S_REQ:
  - Latch `pc_addr` into `mem_addr`.
  - If `pc_addr[1:0]` is not 0: no request is issued. `instr` <= NOP_INSTR and `fault` <= 1. Go to S_VALID.
  - Otherwise assert `mem_req`. If `mem_ack` is high in the same cycle, capture `mem_rdata` and go to S_VALID. Otherwise go to S_WAIT.
- S_WAIT: hold `mem_req` high and `mem_addr` stable until `mem_ack`. On ack, capture `mem_rdata` and set `fault`=0, then go to S_VALID.
- S_VALID: `instr_valid`=1. On `id_ready`, drive `stall_op`=0 for that cycle and go to S_REQ.
- `stall_op`: 2'd2 in every cycle except an acceptance cycle (`instr_valid` && `id_ready`) or a `flush` cycle, which drive 2'd0.
- `flush`:
  - From S_REQ with a request issued but not acked, or from S_WAIT: go to S_DRAIN. Keep `mem_req` high until `mem_ack`, discard that data, then go to S_REQ.
  - From any other state (including S_REQ with misalignment or a same-cycle ack): go to S_REQ.
  - In all cases `instr_valid` is 0 from the next cycle and `instr` <= NOP_INSTR.
- `flush` takes priority over `id_ready` and over `mem_ack` in the same cycle; the acked data is discarded.
- A misaligned fetch is reported once. Decode accepts it like a normal instruction.

## Timing
- Reset values:
  - `stall_op`=2'd2, `mem_req`=0, `mem_addr`=0.
  - `instr`=NOP_INSTR, `instr_valid`=0, `fault`=0.
  - State S_IDLE.
- `mem_req` and `stall_op` are combinational from state and inputs. `mem_addr`, `instr`, `instr_valid`, and `fault` are registered.
- Zero-wait memory: reset release -> S_REQ at cycle 1, `instr_valid` at cycle 2.
- Steady state: 2 cycles per instruction with continuous `id_ready`, plus N cycles of memory wait.
- PC latency: `stall_op`=0 at edge k puts the new `pc_addr` visible at k+1, which is sampled in S_REQ.
- Reset mid-handshake aborts immediately. `mem_req` drops asynchronously and memory must tolerate an abandoned request.

## Structure
- Shared package `core_pkg`:
  - `stall_op` encodings: STALL_ADV=2'd0, STALL_BACK=2'd1, STALL_HOLD=2'd2.
  - Fetch state enum.
  - NOP constant 32'h00000013.
- Single module, no sub-modules. The state register and next-state logic live in one always block; the output registers are separate.

## Test plan
- Reset release, memory acks in the same cycle with 32'h00500093 at addr 0, `id_ready`=1 -> `instr_valid`=1 at cycle 2 with `instr`=32'h00500093; `stall_op`=0 at cycle 2 only.
- Memory with 3-cycle ack latency -> `mem_req` high for 4 cycles with `mem_addr` stable; `stall_op`=2 throughout.
- `id_ready`=0 for 5 cycles in S_VALID -> `instr` unchanged, `stall_op`=2, no `mem_req`.
- `flush` in S_WAIT, ack arrives 2 cycles later with 32'hDEADBEEF -> data discarded, `instr_valid`=0, a new request issues for the target address, for example 32'h00000040.
- `pc_addr`=32'h00000042 -> no `mem_req`; `instr`=32'h00000013, `fault`=1, `instr_valid`=1.
- `reset` asserted while `mem_req`=1 -> all outputs at reset values before the next clock edge.
